block_transfer_controller: RTL and testbench

//  Sequences load/store-multiple (block transfer) instructions for the control unit.

---
 rtl/block_transfer_controller.sv | 146 ++++++++++++++
 tb/tb_block_transfer_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_transfer_controller.sv
// Block transfer (load/store-multiple) sequencer: walks a register list
// lowest-first, issues one memory word per register, computes base writeback.
// Ports: clk, reset (async, active-high); start, reg_list, base_addr, load,
//   u_bit, p_bit, w_bit, base_reg, mem_done in; busy, mem_req, mem_rw,
//   mem_addr, reg_addr, reg_we, wb_en, wb_value, done out.
module block_transfer_controller #(
   parameter int ADDR_W     = 32,
   parameter int WORD_BYTES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       reg_list,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              load,
   input  logic              u_bit,
   input  logic              p_bit,
   input  logic              w_bit,
   input  logic [3:0]        base_reg,
   input  logic              mem_done,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        reg_addr,
   output logic              reg_we,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_value,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE, SETUP, XFER, WB, DONE
   } state_t;

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

   state_t            state, state_nx;
   logic [15:0]       mask, mask_nx;
   logic [ADDR_W-1:0] base_q, addr_q, wb_q;
   logic [ADDR_W-1:0] span, first_addr;
   logic              load_q, u_q, p_q, w_q, base_listed;
   logic [4:0]        n;
   logic [3:0]        low;

   // population count and lowest set bit of the remaining mask
   always_comb begin
      n   = '0;
      low = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + 5'(mask[i]);
      end
      for (int i = 15; i >= 0; i--) begin
         if (mask[i]) low = 4'(i);
      end
   end

   assign mask_nx = mask & ~(16'(1) << low);
   assign span    = ADDR_W'(n) * STEP;

   // lowest address of the block; transfers always ascend from here
   always_comb begin
      if (u_q) first_addr = p_q ? base_q + STEP : base_q;
      else     first_addr = p_q ? base_q - span : base_q - span + STEP;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask        <= '0;
         base_q      <= '0;
         addr_q      <= '0;
         wb_q        <= '0;
         load_q      <= 1'b0;
         u_q         <= 1'b0;
         p_q         <= 1'b0;
         w_q         <= 1'b0;
         base_listed <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               mask        <= reg_list;
               base_q      <= base_addr;
               load_q      <= load;
               u_q         <= u_bit;
               p_q         <= p_bit;
               w_q         <= w_bit;
               base_listed <= reg_list[base_reg];
            end
            SETUP: begin
               addr_q <= first_addr;
               wb_q   <= u_q ? base_q + span : base_q - span;
            end
            XFER: if (mem_done) begin
               mask   <= mask_nx;
               addr_q <= addr_q + STEP;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (start) state_nx = SETUP;
         SETUP: state_nx = (n == 5'd0) ? DONE : XFER;
         XFER:  if (mem_done && mask_nx == 16'h0)
                   state_nx = w_q ? WB : DONE;
         WB:    state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      mem_req  = 1'b0;
      mem_rw   = 1'b0;
      mem_addr = '0;
      reg_addr = '0;
      reg_we   = 1'b0;
      wb_en    = 1'b0;
      done     = 1'b0;
      unique case (state)
         XFER: begin
            mem_req  = 1'b1;
            mem_rw   = load_q;
            mem_addr = addr_q;
            reg_addr = low;
            reg_we   = mem_done & load_q;
         end
         // a loaded base register keeps its loaded value
         WB:   wb_en = ~(load_q & base_listed);
         DONE: done  = 1'b1;
         default: ;
      endcase
   end

   assign wb_value = wb_q;

endmodule

// File: tb/tb_block_transfer_controller.sv
// Self-checking bench for block_transfer_controller: directed cases with
// literal expectations plus randomized transfers against a behavioural model.
module tb_block_transfer_controller;

   logic        clk = 0;
   logic        reset = 1;
   logic        start = 0;
   logic [15:0] reg_list = 0;
   logic [31:0] base_addr = 0;
   logic        load = 0, u_bit = 0, p_bit = 0, w_bit = 0;
   logic [3:0]  base_reg = 0;
   logic        mem_done = 0;
   logic        busy, mem_req, mem_rw, reg_we, wb_en, done;
   logic [31:0] mem_addr, wb_value;
   logic [3:0]  reg_addr;

   block_transfer_controller #(.ADDR_W(32), .WORD_BYTES(4)) dut (
      .clk(clk), .reset(reset), .start(start), .reg_list(reg_list),
      .base_addr(base_addr), .load(load), .u_bit(u_bit), .p_bit(p_bit),
      .w_bit(w_bit), .base_reg(base_reg), .mem_done(mem_done),
      .busy(busy), .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .reg_addr(reg_addr), .reg_we(reg_we), .wb_en(wb_en),
      .wb_value(wb_value), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   int lat_mode = 0;
   bit spur_en = 0;
   int cnt = 0, lat = 0;
   function automatic int pick();
      return (lat_mode >= 0) ? lat_mode : int'($urandom_range(0, 3));
   endfunction
   always begin
      @(posedge clk); #1;
      if (reset) begin
         mem_done = 0; cnt = 0;
      end else begin
         if (mem_done || !mem_req) begin cnt = 0; lat = pick(); end
         if (mem_req) begin
            mem_done = (cnt == lat);
            cnt++;
         end else begin
            mem_done = spur_en && ($urandom_range(0, 3) == 0);
         end
      end
   end

   // ---------------- behavioural model + compare ----------------
   // phase: 0 idle, 1 setup, 2 transfer, 3 writeback, 4 done
   int          ph = 0;
   int          k = 0;
   logic [31:0] q_addr[$];
   logic [3:0]  q_reg[$];
   logic        m_load, m_w, m_wben;
   logic [31:0] m_wbv;
   // event logs for the literal checks
   logic [31:0] log_addr[$];
   logic [3:0]  log_reg[$];
   int we_cnt = 0, wb_cnt = 0, done_cnt = 0, done_lat = 0, start_cyc = 0;

   task automatic build(input logic [15:0] l, input logic [31:0] b,
                        input logic ld, u, p, w, input logic [3:0] br);
      int nn;
      logic [31:0] lo;
      nn = 0;
      for (int i = 0; i < 16; i++) if (l[i]) nn++;
      if (u) lo = p ? b + 4 : b;
      else   lo = p ? b - 32'(4 * nn) : b - 32'(4 * nn) + 4;
      q_addr.delete(); q_reg.delete();
      for (int i = 0; i < 16; i++)
         if (l[i]) begin
            q_addr.push_back(lo + 32'(4 * q_reg.size()));
            q_reg.push_back(4'(i));
         end
      m_load = ld; m_w = w;
      m_wben = !(ld && l[br]);
      m_wbv  = u ? b + 32'(4 * nn) : b - 32'(4 * nn);
      k = 0;
   endtask

   always @(negedge clk) begin
      logic [5:0]  e_fl, a_fl;
      logic [31:0] e_addr;
      logic [3:0]  e_reg;
      e_fl   = '0;
      e_addr = '0;
      e_reg  = '0;
      if (!reset) begin
         e_fl[5] = (ph != 0);
         if (ph == 2) begin
            e_fl[4] = 1; e_fl[3] = m_load;
            e_fl[2] = mem_done && m_load;
            e_addr  = q_addr[k]; e_reg = q_reg[k];
         end
         e_fl[1] = (ph == 3) && m_wben;
         e_fl[0] = (ph == 4);
      end
      a_fl = {busy, mem_req, mem_rw, reg_we, wb_en, done};
      checks++;
      if (a_fl !== e_fl || mem_addr !== e_addr || reg_addr !== e_reg) begin
         failures++;
         $display("FAIL cycle %0d ph=%0d: flags(busy,req,rw,we,wb,done) got %b expected %b addr got %h expected %h reg got %0d expected %0d",
                  cyc, ph, a_fl, e_fl, mem_addr, e_addr, reg_addr, e_reg);
      end
      if (reset) chk("reset_wb_value", wb_value, 32'h0);
      else if (ph == 3) chk("wb_value", wb_value, m_wbv);
      // logs
      if (!reset) begin
         if (mem_req && mem_done) begin
            log_addr.push_back(mem_addr); log_reg.push_back(reg_addr);
         end
         if (reg_we) we_cnt++;
         if (wb_en) wb_cnt++;
         if (done) begin done_cnt++; done_lat = cyc - start_cyc; end
      end
      // advance
      if (reset) ph = 0;
      else case (ph)
         0: if (start) begin
               build(reg_list, base_addr, load, u_bit, p_bit, w_bit, base_reg);
               start_cyc = cyc;
               ph = 1;
            end
         1: ph = (q_reg.size() == 0) ? 4 : 2;
         2: if (mem_done) begin
               k++;
               if (k == q_reg.size()) ph = m_w ? 3 : 4;
            end
         3: ph = 4;
         default: ph = 0;
      endcase
   end

   // ---------------- stimulus ----------------
   bit noise = 0;

   task automatic clear_logs();
      log_addr.delete(); log_reg.delete();
      we_cnt = 0; wb_cnt = 0; done_cnt = 0; done_lat = -1;
   endtask

   task automatic issue(input logic [15:0] l, input logic [31:0] b,
                        input logic ld, u, p, w, input logic [3:0] br);
      @(posedge clk); #1;
      reg_list = l; base_addr = b; load = ld;
      u_bit = u; p_bit = p; w_bit = w; base_reg = br;
      start = 1;
   endtask

   task automatic run_op(input logic [15:0] l, input logic [31:0] b,
                         input logic ld, u, p, w, input logic [3:0] br);
      bit got;
      clear_logs();
      issue(l, b, ld, u, p, w, br);
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(posedge clk); #1;
         if (done) begin
            got = 1;
            start = noise ? 1'($urandom) : 1'b0;
         end else begin
            start = noise ? 1'($urandom) : 1'b0;
            if (noise) reg_list = 16'($urandom);
         end
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL timeout: no done within 400 cycles");
      end
      @(posedge clk); #1;
      start = 0;
   endtask

   initial begin
      #2;
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_addr", mem_addr, 0);
      repeat (2) @(posedge clk);
      #1 reset = 0;

      // 1: LDM IA
      lat_mode = 0;
      run_op(16'h0005, 32'h100, 1, 1, 0, 0, 4'd0);
      chk("t1_n", log_addr.size(), 2);
      chk("t1_a0", log_addr[0], 32'h100);
      chk("t1_r0", log_reg[0], 0);
      chk("t1_a1", log_addr[1], 32'h104);
      chk("t1_r1", log_reg[1], 2);
      chk("t1_we", we_cnt, 2);
      chk("t1_wb", wb_cnt, 0);
      chk("t1_lat", done_lat, 4);

      // 2: STM DB
      run_op(16'h8001, 32'h200, 0, 0, 1, 1, 4'd0);
      chk("t2_a0", log_addr[0], 32'h1F8);
      chk("t2_r0", log_reg[0], 0);
      chk("t2_a1", log_addr[1], 32'h1FC);
      chk("t2_r1", log_reg[1], 15);
      chk("t2_we", we_cnt, 0);
      chk("t2_wb", wb_cnt, 1);
      chk("t2_wbv", wb_value, 32'h1F8);
      chk("t2_lat", done_lat, 5);

      // 3: empty list
      run_op(16'h0000, 32'h300, 1, 1, 0, 1, 4'd0);
      chk("t3_n", log_addr.size(), 0);
      chk("t3_wb", wb_cnt, 0);
      chk("t3_lat", done_lat, 2);

      // 4: LDM IB full list, slow memory
      lat_mode = 3;
      run_op(16'hFFFF, 32'h0, 1, 1, 1, 1, 4'd13);
      chk("t4_n", log_addr.size(), 16);
      chk("t4_a0", log_addr[0], 32'h4);
      chk("t4_a15", log_addr[15], 32'h40);
      chk("t4_r15", log_reg[15], 15);
      chk("t4_we", we_cnt, 16);
      chk("t4_wbv", wb_value, 32'h40);
      chk("t4_lat", done_lat, 1 + 16 * 4 + 2);

      // 5: base register in the load list
      lat_mode = 0;
      run_op(16'h0012, 32'h500, 1, 1, 0, 1, 4'd4);
      chk("t5_r0", log_reg[0], 1);
      chk("t5_r1", log_reg[1], 4);
      chk("t5_we", we_cnt, 2);
      chk("t5_wb", wb_cnt, 0);

      // 6: reset during the second transfer
      lat_mode = 1;
      clear_logs();
      issue(16'h00F0, 32'h600, 1, 1, 0, 1, 4'd0);
      @(posedge clk); #1 start = 0;
      for (int i = 0; i < 50 && log_addr.size() < 1; i++) @(posedge clk);
      @(posedge clk); #3;
      reset = 1;
      #1;
      chk("t6_req", {31'b0, mem_req}, 0);
      chk("t6_busy", {31'b0, busy}, 0);
      chk("t6_addr", mem_addr, 0);
      chk("t6_we", {31'b0, reg_we}, 0);
      @(posedge clk); #1 reset = 0;
      repeat (3) @(posedge clk);
      chk("t6_done", done_cnt, 0);
      chk("t6_wbc", wb_cnt, 0);
      lat_mode = 0;
      run_op(16'h0003, 32'h10, 0, 0, 0, 0, 4'd0);
      chk("t6_a0", log_addr[0], 32'hC);
      chk("t6_r0", log_reg[0], 0);
      chk("t6_a1", log_addr[1], 32'h10);
      chk("t6_r1", log_reg[1], 1);

      // randomized operations
      lat_mode = -1;
      spur_en = 1;
      noise = 1;
      for (int t = 0; t < 60; t++) begin
         logic [15:0] l;
         l = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
         run_op(l, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 4'($urandom));
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
